cache_ctrl: RTL and testbench

Blocking controller for the 2-way set-associative data cache. It accepts one CPU load/store at a time and sequences `cache_table` through lookup, hit update, dirty-victim writeback and line refill, with true-LRU replacement per set. After reset it runs an invalidation sweep because the table storage has no reset. It sits between the CPU memory stage and the AXI bridge, and is the only master of `cache_table`.

---
 rtl/cache_ctrl_pkg.sv | 40 ++++
 rtl/cache_ctrl_lru.sv | 26 ++
 rtl/cache_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, table-entry layout, write-type encodings and FSM states
// for the 2-way set-associative data cache controller.
package cache_ctrl_pkg;

  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 20;
  localparam int LINE_W   = 128;
  localparam int ENTRY_W  = TAG_W + 2 + LINE_W;
  localparam int SETS     = 1 << INDEX_W;

  typedef enum logic [1:0] {
    WT_READ = 2'b00,
    WT_PART = 2'b01,
    WT_FULL = 2'b10
  } w_type_e;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    WB,
    RD,
    REFILL
  } state_e;

  // Matches the 150-bit table entry: {tag, valid, dirty, data}
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              valid;
    logic              dirty;
    logic [LINE_W-1:0] data;
  } entry_t;

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0] word);
    return line[word*32 +: 32];
  endfunction

endpackage

// File: rtl/cache_ctrl_lru.sv
// True-LRU state for a 2-way cache: one bit per set naming the way to evict next.
module cache_lru
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  output logic               lru_way,
  input  logic               upd_en,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               mru_way
);

  logic [SETS-1:0] lru;

  always_ff @(posedge clk) begin
    if (rst) begin
      lru <= '0;
    end else if (upd_en) begin
      lru[upd_idx] <= ~mru_way;
    end
  end

  assign lru_way = lru[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Blocking 2-way set-associative cache controller: lookup, hit update,
// dirty writeback, line refill and post-reset invalidation sweep.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [31:0]         cpu_addr,
  input  logic [3:0]          cpu_wstrb,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_addr_ok,
  output logic                cpu_data_ok,
  output logic [31:0]         cpu_rdata,
  output logic                tbl_req,
  output logic [INDEX_W-1:0]  tbl_r_index,
  output logic                tbl_way,
  output logic [INDEX_W-1:0]  tbl_w_index,
  output logic [1:0]          tbl_w_type,
  output logic [OFFSET_W-1:0] tbl_offset,
  output logic [3:0]          tbl_wstrb,
  output logic [ENTRY_W-1:0]  tbl_w_data,
  input  logic [2*ENTRY_W-1:0] tbl_r_data,
  output logic                rd_req,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data,
  output logic                wr_req,
  output logic [31:0]         wr_addr,
  output logic [LINE_W-1:0]   wr_data,
  input  logic                wr_rdy
);

  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        word,
                                                   input logic [3:0]        strb,
                                                   input logic [31:0]       data);
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[word*32 + b*8 +: 8] = data[b*8 +: 8];
    end
    return r;
  endfunction

  state_e state, state_nxt;
  logic [INDEX_W:0]   init_cnt;
  logic [1:0]         beat;

  logic [31:0]        req_addr;
  logic               req_wr;
  logic [3:0]         req_wstrb;
  logic [31:0]        req_wdata;
  logic               vic_way;
  logic [TAG_W-1:0]   vic_tag;
  logic [LINE_W-1:0]  vic_data;
  logic [LINE_W-1:0]  line_buf;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_word;
  entry_t             way0_e, way1_e, miss_e;
  logic               hit0, hit1, hit, miss_way, lru_way;
  logic [LINE_W-1:0]  hit_line, fill_line, final_line;
  logic               lru_en, lru_mru;

  assign req_tag  = req_addr[31:12];
  assign req_idx  = req_addr[11:4];
  assign req_word = req_addr[3:2];

  assign way0_e   = tbl_r_data[ENTRY_W-1:0];
  assign way1_e   = tbl_r_data[2*ENTRY_W-1:ENTRY_W];
  assign hit0     = way0_e.valid && (way0_e.tag == req_tag);
  assign hit1     = way1_e.valid && (way1_e.tag == req_tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit1 ? way1_e.data : way0_e.data;

  // Prefer an empty way before consulting LRU
  assign miss_way = !way0_e.valid ? 1'b0 : (!way1_e.valid ? 1'b1 : lru_way);
  assign miss_e   = miss_way ? way1_e : way0_e;

  always_comb begin
    fill_line = line_buf;
    fill_line[beat*32 +: 32] = ret_data;
    final_line = req_wr ? merge_line(fill_line, req_word, req_wstrb, req_wdata) : fill_line;
  end

  cache_lru u_lru (
    .clk     (clk),
    .rst     (rst),
    .idx     (req_idx),
    .lru_way (lru_way),
    .upd_en  (lru_en),
    .upd_idx (req_idx),
    .mru_way (lru_mru)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
      beat     <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (state == RD) beat <= '0;
      else if (state == REFILL && ret_valid) beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      req_addr  <= cpu_addr;
      req_wr    <= cpu_wr;
      req_wstrb <= cpu_wstrb;
      req_wdata <= cpu_wdata;
    end
    if (state == LOOKUP) begin
      vic_way  <= miss_way;
      vic_tag  <= miss_e.tag;
      vic_data <= miss_e.data;
    end
    if (state == REFILL && ret_valid) line_buf <= fill_line;
  end

  always_comb begin
    state_nxt   = state;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    tbl_req     = 1'b0;
    tbl_r_index = '0;
    tbl_way     = 1'b0;
    tbl_w_index = '0;
    tbl_w_type  = WT_READ;
    tbl_offset  = '0;
    tbl_wstrb   = '0;
    tbl_w_data  = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    lru_en      = 1'b0;
    lru_mru     = 1'b0;
    // Everything stays quiet during the reset cycle itself
    if (!rst) begin
      case (state)
        INIT: begin
          tbl_req     = 1'b1;
          tbl_w_type  = WT_FULL;
          tbl_way     = init_cnt[0];
          tbl_w_index = init_cnt[INDEX_W:1];
          if (&init_cnt) state_nxt = IDLE;
        end
        IDLE: begin
          cpu_addr_ok = cpu_req;
          if (cpu_req) begin
            tbl_req     = 1'b1;
            tbl_r_index = cpu_addr[11:4];
            state_nxt   = LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data_ok = 1'b1;
            lru_en      = 1'b1;
            lru_mru     = hit1;
            state_nxt   = IDLE;
            if (req_wr) begin
              tbl_req     = 1'b1;
              tbl_w_type  = WT_FULL;
              tbl_way     = hit1;
              tbl_w_index = req_idx;
              tbl_offset  = req_addr[3:0];
              tbl_wstrb   = req_wstrb;
              tbl_w_data  = {req_tag, 1'b1, 1'b1,
                             merge_line(hit_line, req_word, req_wstrb, req_wdata)};
            end else begin
              cpu_rdata = line_word(hit_line, req_word);
            end
          end else begin
            state_nxt = (miss_e.valid && miss_e.dirty) ? WB : RD;
          end
        end
        WB: begin
          wr_req  = 1'b1;
          wr_addr = {vic_tag, req_idx, 4'b0};
          wr_data = vic_data;
          if (wr_rdy) state_nxt = RD;
        end
        RD: begin
          rd_req  = 1'b1;
          rd_addr = {req_tag, req_idx, 4'b0};
          if (rd_rdy) state_nxt = REFILL;
        end
        REFILL: begin
          if (ret_valid && ret_last) begin
            tbl_req     = 1'b1;
            tbl_w_type  = WT_FULL;
            tbl_way     = vic_way;
            tbl_w_index = req_idx;
            tbl_offset  = req_addr[3:0];
            tbl_wstrb   = req_wr ? req_wstrb : 4'b0;
            tbl_w_data  = {req_tag, 1'b1, req_wr, final_line};
            lru_en      = 1'b1;
            lru_mru     = vic_way;
            cpu_data_ok = 1'b1;
            if (!req_wr) cpu_rdata = line_word(fill_line, req_word);
            state_nxt   = IDLE;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  refill_last_on_fourth_beat: assert property (@(posedge clk) disable iff (rst)
    (state == REFILL && ret_valid && ret_last) |-> (beat == 2'd3));

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural cache_table model.
module tb_cache_ctrl;

  logic         clk;
  logic         rst;
  logic         cpu_req, cpu_wr;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic         cpu_addr_ok, cpu_data_ok;
  logic [31:0]  cpu_rdata;
  logic         tbl_req, tbl_way;
  logic [7:0]   tbl_r_index, tbl_w_index;
  logic [1:0]   tbl_w_type;
  logic [3:0]   tbl_offset, tbl_wstrb;
  logic [149:0] tbl_w_data;
  logic [299:0] tbl_r_data;
  logic         rd_req, rd_rdy;
  logic [31:0]  rd_addr;
  logic         ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req, wr_rdy;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .tbl_req(tbl_req), .tbl_r_index(tbl_r_index), .tbl_way(tbl_way),
    .tbl_w_index(tbl_w_index), .tbl_w_type(tbl_w_type), .tbl_offset(tbl_offset),
    .tbl_wstrb(tbl_wstrb), .tbl_w_data(tbl_w_data), .tbl_r_data(tbl_r_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cache_table: unreset storage, read data one cycle after request
  logic [149:0] mem0 [256];
  logic [149:0] mem1 [256];
  always @(posedge clk) begin
    if (tbl_req && tbl_w_type == 2'b00)
      tbl_r_data <= {mem1[tbl_r_index], mem0[tbl_r_index]};
    if (tbl_req && tbl_w_type == 2'b10) begin
      if (tbl_way) mem1[tbl_w_index] <= tbl_w_data;
      else         mem0[tbl_w_index] <= tbl_w_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic wr, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wd);
    @(negedge clk);
    ret_valid = 0; ret_last = 0; rd_rdy = 0; wr_rdy = 0;
    cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wd;
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    @(negedge clk);
    rd_rdy = 0; ret_valid = 1; ret_data = d; ret_last = last;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if ({cpu_addr_ok, cpu_data_ok, cpu_rdata, tbl_req, tbl_r_index, tbl_way, tbl_w_index,
         tbl_w_type, tbl_offset, tbl_wstrb, tbl_w_data, rd_req, rd_addr, wr_req,
         wr_addr, wr_data} !== '0)
      $display("FAIL reset_outputs: got nonzero output during reset, required all zero (addr_ok=%b tbl_req=%b rd_req=%b wr_req=%b)",
               cpu_addr_ok, tbl_req, rd_req, wr_req);
    if ({cpu_addr_ok, cpu_data_ok, cpu_rdata, tbl_req, tbl_r_index, tbl_way, tbl_w_index,
         tbl_w_type, tbl_offset, tbl_wstrb, tbl_w_data, rd_req, rd_addr, wr_req,
         wr_addr, wr_data} !== '0) n_fail++;
  endtask

  task automatic test_init();
    int bad;
    logic [511:0] covered;
    bad = 0;
    covered = '0;
    @(negedge clk);
    rst = 0; cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0000;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (cpu_addr_ok !== 1'b0 || tbl_req !== 1'b1 || tbl_w_type !== 2'b10 || tbl_w_data !== '0)
        bad++;
      else
        covered[{tbl_w_index, tbl_way}] = 1'b1;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_writes: %0d bad sweep cycles, required 0", bad);
    end
    n_tests++;
    if (covered !== {512{1'b1}}) begin
      n_fail++;
      $display("FAIL init_coverage: %0d entries cleared, required 512", $countones(covered));
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (cpu_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL init_exit_addr_ok: got %b at cycle 512, required 1", cpu_addr_ok);
    end
    cpu_req = 0;
  endtask

  task automatic test_cold_load();
    logic [149:0] exp_e;
    exp_e = {20'h10000, 1'b1, 1'b0, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    drive_req(0, 32'h1000_0024, 4'h0, 32'h0);
    n_tests++;
    if (cpu_addr_ok !== 1'b1 || tbl_req !== 1'b1 || tbl_w_type !== 2'b00 || tbl_r_index !== 8'h02) begin
      n_fail++;
      $display("FAIL cold_accept: addr_ok=%b tbl_req=%b w_type=%b r_index=%h, required 1 1 00 02",
               cpu_addr_ok, tbl_req, tbl_w_type, tbl_r_index);
    end
    @(negedge clk); cpu_req = 0; #1;
    n_tests++;
    if (cpu_data_ok !== 1'b0 || rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_lookup: data_ok=%b rd_req=%b, required 0 0", cpu_data_ok, rd_req);
    end
    @(negedge clk); #1;
    n_tests++;
    if (rd_req !== 1'b1 || rd_addr !== 32'h1000_0020 || wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_rd_req: rd_req=%b rd_addr=%h wr_req=%b, required 1 10000020 0",
               rd_req, rd_addr, wr_req);
    end
    rd_rdy = 1;
    drive_beat(32'hA0, 0);
    n_tests++;
    if (cpu_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_beat0_data_ok: got %b required 0", cpu_data_ok);
    end
    drive_beat(32'hA1, 0);
    drive_beat(32'hA2, 0);
    drive_beat(32'hA3, 1);
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hA1) begin
      n_fail++;
      $display("FAIL cold_rdata: data_ok=%b rdata=%h, required 1 000000a1", cpu_data_ok, cpu_rdata);
    end
    n_tests++;
    if (tbl_req !== 1'b1 || tbl_w_type !== 2'b10 || tbl_way !== 1'b0 || tbl_w_index !== 8'h02 ||
        tbl_w_data !== exp_e) begin
      n_fail++;
      $display("FAIL cold_fill_write: way=%b idx=%h data=%h, required 0 02 %h",
               tbl_way, tbl_w_index, tbl_w_data, exp_e);
    end
  endtask

  task automatic test_load_hit();
    drive_req(0, 32'h1000_0028, 4'h0, 32'h0);
    n_tests++;
    if (cpu_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_accept: addr_ok=%b required 1", cpu_addr_ok);
    end
    @(negedge clk); cpu_req = 0; #1;
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hA2 || rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_rdata: data_ok=%b rdata=%h rd_req=%b, required 1 000000a2 0",
               cpu_data_ok, cpu_rdata, rd_req);
    end
  endtask

  task automatic test_store_hit();
    logic [149:0] exp_e;
    exp_e = {20'h10000, 1'b1, 1'b1, 32'hA3, 32'hA2, 32'hA1, 32'h0000_BEEF};
    drive_req(1, 32'h1000_0020, 4'b0011, 32'hFFFF_BEEF);
    @(negedge clk); cpu_req = 0; #1;
    n_tests++;
    if (cpu_data_ok !== 1'b1 || tbl_req !== 1'b1 || tbl_w_type !== 2'b10 || tbl_way !== 1'b0 ||
        tbl_w_index !== 8'h02 || tbl_w_data !== exp_e) begin
      n_fail++;
      $display("FAIL store_hit_write: data_ok=%b way=%b idx=%h data=%h, required 1 0 02 %h",
               cpu_data_ok, tbl_way, tbl_w_index, tbl_w_data, exp_e);
    end
  endtask

  task automatic test_dirty_evict();
    int bad;
    logic [127:0] old_line;
    logic [149:0] exp_e;
    old_line = {32'hA3, 32'hA2, 32'hA1, 32'h0000_BEEF};
    // Fill way1 of set 2 with a clean line
    drive_req(0, 32'h2000_0020, 4'h0, 32'h0);
    @(negedge clk); cpu_req = 0;
    @(negedge clk); #1;
    n_tests++;
    if (rd_req !== 1'b1 || wr_req !== 1'b0 || rd_addr !== 32'h2000_0020) begin
      n_fail++;
      $display("FAIL fill_way1_rd: rd_req=%b wr_req=%b rd_addr=%h, required 1 0 20000020",
               rd_req, wr_req, rd_addr);
    end
    rd_rdy = 1;
    drive_beat(32'hB0, 0);
    drive_beat(32'hB1, 0);
    drive_beat(32'hB2, 0);
    drive_beat(32'hB3, 1);
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hB0 || tbl_way !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_way1_done: data_ok=%b rdata=%h way=%b, required 1 000000b0 1",
               cpu_data_ok, cpu_rdata, tbl_way);
    end
    // Store miss to set 2: LRU points at dirty way0
    drive_req(1, 32'h3000_0024, 4'b1111, 32'h1234_5678);
    @(negedge clk); cpu_req = 0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); wr_rdy = 0; #1;
      if (wr_req !== 1'b1 || rd_req !== 1'b0 || wr_addr !== 32'h1000_0020 || wr_data !== old_line)
        bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL evict_wr_hold: %0d bad cycles (wr_req=%b wr_addr=%h wr_data=%h), required 0",
               bad, wr_req, wr_addr, wr_data);
    end
    @(negedge clk); wr_rdy = 1; #1;
    n_tests++;
    if (wr_req !== 1'b1 || rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_wr_handshake: wr_req=%b rd_req=%b, required 1 0", wr_req, rd_req);
    end
    @(negedge clk); wr_rdy = 0; #1;
    n_tests++;
    if (rd_req !== 1'b1 || wr_req !== 1'b0 || rd_addr !== 32'h3000_0020) begin
      n_fail++;
      $display("FAIL evict_rd_req: rd_req=%b wr_req=%b rd_addr=%h, required 1 0 30000020",
               rd_req, wr_req, rd_addr);
    end
    rd_rdy = 1;
    drive_beat(32'hC0, 0);
    drive_beat(32'hC1, 0);
    drive_beat(32'hC2, 0);
    drive_beat(32'hC3, 1);
    exp_e = {20'h30000, 1'b1, 1'b1, 32'hC3, 32'hC2, 32'h1234_5678, 32'hC0};
    n_tests++;
    if (cpu_data_ok !== 1'b1 || tbl_req !== 1'b1 || tbl_way !== 1'b0 || tbl_w_data !== exp_e) begin
      n_fail++;
      $display("FAIL evict_store_fill: data_ok=%b way=%b data=%h, required 1 0 %h",
               cpu_data_ok, tbl_way, tbl_w_data, exp_e);
    end
  endtask

  task automatic test_back_to_back();
    drive_req(0, 32'h3000_0024, 4'h0, 32'h0);
    @(negedge clk);
    cpu_addr = 32'h2000_0028;
    #1;
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h1234_5678 || cpu_addr_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: data_ok=%b rdata=%h addr_ok=%b, required 1 12345678 0",
               cpu_data_ok, cpu_rdata, cpu_addr_ok);
    end
    @(negedge clk); #1;
    n_tests++;
    if (cpu_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: addr_ok=%b required 1", cpu_addr_ok);
    end
    @(negedge clk); cpu_req = 0; #1;
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hB2) begin
      n_fail++;
      $display("FAIL b2b_second: data_ok=%b rdata=%h, required 1 000000b2", cpu_data_ok, cpu_rdata);
    end
  endtask

  task automatic test_bypass();
    drive_req(0, 32'h4000_004C, 4'h0, 32'h0);
    @(negedge clk); cpu_req = 0;
    @(negedge clk); rd_rdy = 1;
    drive_beat(32'hD0, 0);
    drive_beat(32'hD1, 0);
    drive_beat(32'hD2, 0);
    drive_beat(32'hD3, 1);
    n_tests++;
    if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hD3 || tbl_w_index !== 8'h04) begin
      n_fail++;
      $display("FAIL bypass_word3: data_ok=%b rdata=%h idx=%h, required 1 000000d3 04",
               cpu_data_ok, cpu_rdata, tbl_w_index);
    end
  endtask

  task automatic test_reset_mid_refill();
    int k;
    drive_req(0, 32'h5000_0050, 4'h0, 32'h0);
    @(negedge clk); cpu_req = 0;
    @(negedge clk); rd_rdy = 1;
    drive_beat(32'hE0, 0);
    @(negedge clk);
    rst = 1; ret_valid = 1; ret_data = 32'hE1; ret_last = 0;
    #1;
    n_tests++;
    if (rd_req !== 1'b0 || wr_req !== 1'b0 || cpu_data_ok !== 1'b0 || tbl_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cycle_outputs: rd_req=%b wr_req=%b data_ok=%b tbl_req=%b, required 0 0 0 0",
               rd_req, wr_req, cpu_data_ok, tbl_req);
    end
    @(negedge clk);
    rst = 0; ret_valid = 0;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h1000_0028;
    #1;
    n_tests++;
    if (rd_req !== 1'b0 || wr_req !== 1'b0 || cpu_data_ok !== 1'b0 || tbl_req !== 1'b1 ||
        tbl_w_type !== 2'b10 || tbl_w_index !== 8'h00 || tbl_way !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reinit: rd_req=%b wr_req=%b data_ok=%b tbl_req=%b w_type=%b idx=%h way=%b, required 0 0 0 1 10 00 0",
               rd_req, wr_req, cpu_data_ok, tbl_req, tbl_w_type, tbl_w_index, tbl_way);
    end
    k = 0;
    while (cpu_addr_ok !== 1'b1 && k < 600) begin
      @(negedge clk); #1;
      k++;
    end
    n_tests++;
    if (k !== 512) begin
      n_fail++;
      $display("FAIL rst_sweep_len: addr_ok after %0d cycles, required 512", k);
    end
    @(negedge clk); cpu_req = 0; #1;
    n_tests++;
    if (cpu_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_invalidated_lookup: data_ok=%b, required 0", cpu_data_ok);
    end
    @(negedge clk); #1;
    n_tests++;
    if (rd_req !== 1'b1 || rd_addr !== 32'h1000_0020) begin
      n_fail++;
      $display("FAIL rst_invalidated_miss: rd_req=%b rd_addr=%h, required 1 10000020", rd_req, rd_addr);
    end
  endtask

  initial begin
    rst = 1; cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
    rd_rdy = 0; wr_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
    test_reset();
    test_init();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_dirty_evict();
    test_back_to_back();
    test_bypass();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
